// File: rtl/branch_cmp_ctrl_pkg.sv
// branch_cmp_ctrl_pkg: shared widths, branch type encodings and helpers for the branch comparator controller
package branch_cmp_ctrl_pkg;
  localparam int BR_TYPE_W = 3;
  localparam int REG_W = 5;
  localparam int TNEW_W = 2;
  typedef enum logic [BR_TYPE_W-1:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_type_e;
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  function automatic logic uses_rt(input logic [BR_TYPE_W-1:0] t);
    return t == BR_BEQ || t == BR_BNE;
  endfunction
endpackage

// File: rtl/branch_cmp_ctrl_br_cond_eval.sv
// br_cond_eval: combinational branch condition evaluation on forwarded operands
module br_cond_eval
  import branch_cmp_ctrl_pkg::*;
(
  input  logic [31:0]          d1,
  input  logic [31:0]          d2,
  input  logic [BR_TYPE_W-1:0] br_type,
  output logic                 cond
);
  logic zero, neg;
  assign zero = d1 == 32'd0;
  assign neg = d1[31];
  always_comb
    cond = br_type == BR_BEQ  ? d1 == d2 :
           br_type == BR_BNE  ? d1 != d2 :
           br_type == BR_BLEZ ? neg | zero :
           br_type == BR_BGTZ ? ~neg & ~zero :
           br_type == BR_BLTZ ? neg :
           br_type == BR_BGEZ ? ~neg : 1'b0;
endmodule

// File: rtl/branch_cmp_ctrl.sv
// branch_cmp_ctrl: ID-stage branch resolve/stall decision, stall watchdog and branch perf counters
module branch_cmp_ctrl
  import branch_cmp_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_br_valid,
  input  logic [BR_TYPE_W-1:0] id_br_type,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic                 e_wr_en,
  input  logic [REG_W-1:0]     e_wr_addr,
  input  logic [TNEW_W-1:0]    e_tnew,
  input  logic                 m_wr_en,
  input  logic [REG_W-1:0]     m_wr_addr,
  input  logic [TNEW_W-1:0]    m_tnew,
  input  logic [31:0]          d1,
  input  logic [31:0]          d2,
  input  logic                 perf_clr,
  output logic                 stall,
  output logic                 br_resolve,
  output logic                 br_taken,
  output logic                 stall_err,
  output logic [CNT_W-1:0]     br_total,
  output logic [CNT_W-1:0]     br_taken_cnt
);
  localparam int SC_W = MAX_STALL <= 3 ? 2 : $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL);
  state_e state, state_nxt;
  logic [SC_W-1:0] cnt, cnt_nxt;
  logic hz_rs, hz_rt, hazard, cond, err_set;
  assign hz_rs = |id_rs & ((e_wr_en & e_wr_addr == id_rs & |e_tnew) |
                           (m_wr_en & m_wr_addr == id_rs & |m_tnew));
  assign hz_rt = uses_rt(id_br_type) & |id_rt &
                 ((e_wr_en & e_wr_addr == id_rt & |e_tnew) |
                  (m_wr_en & m_wr_addr == id_rt & |m_tnew));
  assign hazard = hz_rs | hz_rt;
  // reset gates the combinational outputs so PC-hold/NPC logic sees nothing while in reset
  assign stall = reset & id_br_valid & hazard;
  assign br_resolve = reset & id_br_valid & ~hazard;
  assign br_taken = br_resolve & cond;
  br_cond_eval u_cond (
    .d1(d1),
    .d2(d2),
    .br_type(id_br_type),
    .cond(cond)
  );
  always_comb begin
    state_nxt = S_IDLE;
    cnt_nxt = '0;
    if (stall) begin
      state_nxt = S_WAIT;
      cnt_nxt = state == S_IDLE ? SC_W'(1) : cnt == SC_MAX ? cnt : cnt + SC_W'(1);
    end
  end
  assign err_set = stall & cnt_nxt == SC_MAX;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      stall_err <= 1'b0;
      br_total <= '0;
      br_taken_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      stall_err <= perf_clr ? 1'b0 : stall_err | err_set;
      br_total <= perf_clr ? '0 : br_resolve & ~&br_total ? br_total + CNT_W'(1) : br_total;
      br_taken_cnt <= perf_clr ? '0 : br_taken & ~&br_taken_cnt ? br_taken_cnt + CNT_W'(1) : br_taken_cnt;
    end
  end
endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// tb_branch_cmp_ctrl: directed plus random stimulus against a behavioural model of the branch controller
module tb_branch_cmp_ctrl;
  localparam int MS = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 0;
  logic id_br_valid = 0, e_wr_en = 0, m_wr_en = 0, perf_clr = 0;
  logic [2:0] id_br_type = 0;
  logic [4:0] id_rs = 0, id_rt = 0, e_wr_addr = 0, m_wr_addr = 0;
  logic [1:0] e_tnew = 0, m_tnew = 0;
  logic [31:0] d1 = 0, d2 = 0;
  logic stall, br_resolve, br_taken, stall_err;
  logic [CW-1:0] br_total, br_taken_cnt;
  int checks = 0, errors = 0;
  int m_run = 0, m_tot = 0, m_tkn = 0;
  bit m_err = 0;
  branch_cmp_ctrl #(.MAX_STALL(MS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_br_valid(id_br_valid), .id_br_type(id_br_type),
    .id_rs(id_rs), .id_rt(id_rt), .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr), .e_tnew(e_tnew),
    .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr), .m_tnew(m_tnew), .d1(d1), .d2(d2),
    .perf_clr(perf_clr), .stall(stall), .br_resolve(br_resolve), .br_taken(br_taken),
    .stall_err(stall_err), .br_total(br_total), .br_taken_cnt(br_taken_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit busy(input logic [4:0] r);
    return r != 0 && ((e_wr_en && e_wr_addr == r && e_tnew != 0) ||
                      (m_wr_en && m_wr_addr == r && m_tnew != 0));
  endfunction
  function automatic bit taken_m();
    case (id_br_type)
      0: return d1 == d2;
      1: return d1 != d2;
      2: return $signed(d1) <= 0;
      3: return $signed(d1) > 0;
      4: return $signed(d1) < 0;
      5: return $signed(d1) >= 0;
      default: return 0;
    endcase
  endfunction
  task automatic quiet();
    id_br_valid = 0; e_wr_en = 0; m_wr_en = 0; perf_clr = 0;
    id_br_type = 0; id_rs = 0; id_rt = 0; e_wr_addr = 0; m_wr_addr = 0;
    e_tnew = 0; m_tnew = 0; d1 = 0; d2 = 0;
  endtask
  task automatic br(input int t, input int rs, input int rt, input logic [31:0] a, input logic [31:0] b);
    id_br_valid = 1; id_br_type = 3'(t); id_rs = 5'(rs); id_rt = 5'(rt); d1 = a; d2 = b;
  endtask
  task automatic step();
    bit haz, es, er, et;
    haz = busy(id_rs) || (id_br_type < 2 && busy(id_rt));
    es = id_br_valid && haz;
    er = id_br_valid && !haz;
    et = er && taken_m();
    #1;
    chk("stall", stall, es);
    chk("resolve", br_resolve, er);
    chk("taken", br_taken, et);
    chk("stall_err", stall_err, m_err);
    chk("br_total", br_total, m_tot);
    chk("br_taken_cnt", br_taken_cnt, m_tkn);
    @(posedge clk);
    if (perf_clr) begin
      m_tot = 0; m_tkn = 0;
    end else if (er) begin
      m_tot = m_tot < CMAX ? m_tot + 1 : CMAX;
      if (et) m_tkn = m_tkn < CMAX ? m_tkn + 1 : CMAX;
    end
    m_run = es ? m_run + 1 : 0;
    if (perf_clr) m_err = 0;
    else if (m_run >= MS) m_err = 1;
    @(negedge clk);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 4)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    quiet();
    br(0, 8, 9, 1, 1);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_resolve", br_resolve, 0);
    chk("rst_total", br_total, 0);
    chk("rst_err", stall_err, 0);
    @(negedge clk);
    reset = 1;
    quiet();
    br(0, 8, 9, 32'h1234, 32'h1234);
    step();
    chk("first_total", br_total, 1);
    chk("first_taken", br_taken_cnt, 1);
    br(1, 8, 0, 5, 7); e_wr_en = 1; e_wr_addr = 8; e_tnew = 1;
    step();
    e_tnew = 0;
    step();
    quiet();
    br(2, 1, 0, 32'h8000_0000, 0); step();
    br(3, 1, 0, 0, 0); step();
    br(5, 1, 0, 0, 0); step();
    br(2, 1, 9, 32'h5, 0); e_wr_en = 1; e_wr_addr = 9; e_tnew = 2; step();
    quiet();
    br(0, 0, 0, 3, 3); e_wr_en = 1; e_wr_addr = 0; e_tnew = 2; step();
    quiet();
    br(4, 8, 0, 32'hffff_fff0, 0); m_wr_en = 1; m_wr_addr = 8; m_tnew = 1;
    repeat (4) step();
    chk("err_set", stall_err, 1);
    quiet();
    repeat (2) step();
    perf_clr = 1; step();
    perf_clr = 0;
    chk("err_clr", stall_err, 0);
    br(0, 8, 8, 1, 1); e_wr_en = 1; e_wr_addr = 8; e_tnew = 1; step();
    id_br_valid = 0; step();
    quiet();
    br(1, 8, 0, 1, 2); m_wr_en = 1; m_wr_addr = 8; m_tnew = 3; e_wr_en = 1; e_wr_addr = 8; e_tnew = 0;
    repeat (4) step();
    #2;
    reset = 0;
    #1;
    chk("async_stall", stall, 0);
    chk("async_total", br_total, 0);
    chk("async_err", stall_err, 0);
    m_run = 0; m_tot = 0; m_tkn = 0; m_err = 0;
    @(negedge clk);
    reset = 1;
    quiet();
    br(1, 3, 4, 1, 2);
    repeat (CMAX + 4) step();
    chk("sat_total", br_total, CMAX);
    perf_clr = 1; step();
    perf_clr = 0;
    chk("clr_pri_total", br_total, 0);
    chk("clr_pri_taken", br_taken_cnt, 0);
    for (int i = 0; i < 600; i++) begin
      id_br_valid = $urandom % 4 != 0;
      id_br_type = 3'($urandom);
      id_rs = ($urandom % 2) ? 5'd8 : 5'($urandom % 3 == 0 ? 0 : $urandom);
      id_rt = ($urandom % 2) ? 5'd9 : 5'($urandom);
      e_wr_en = 1'($urandom); e_wr_addr = ($urandom % 2) ? 5'd8 : 5'($urandom % 10);
      m_wr_en = 1'($urandom); m_wr_addr = ($urandom % 2) ? 5'd9 : 5'($urandom % 10);
      e_tnew = 2'($urandom); m_tnew = 2'($urandom);
      d1 = pick();
      d2 = ($urandom % 3 == 0) ? d1 : pick();
      perf_clr = $urandom % 20 == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_cmp_ctrl.md
Name: branch_cmp_ctrl

Overview:
- ID-stage controller that sequences the branch comparator: decides whether the branch can resolve this cycle or must stall for an in-flight producer, then evaluates the branch condition.
- Tracks the stall with a small FSM and stall counter, flags pathological stalls, and keeps saturating branch performance counters.
- Sits between the hazard inputs from E/M and the NPC select / PC-hold logic.

Parameters:
- MAX_STALL, 3, stall cycles after which stall_err is set (sticky).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_br_valid  in  1  branch instruction present in ID.
- id_br_type  in  3  0=BEQ 1=BNE 2=BLEZ 3=BGTZ 4=BLTZ 5=BGEZ; 6,7 = never taken.
- id_rs  in  5  rs index.
- id_rt  in  5  rt index, used only for BEQ/BNE.
- e_wr_en, m_wr_en  in  1 each  E/M stage will write a GPR.
- e_wr_addr, m_wr_addr  in  5 each  destination register.
- e_tnew, m_tnew  in  2 each  cycles until the producer's result is forwardable; 0 = ready.
- d1, d2  in  32 each  forwarded rs/rt values.
- perf_clr  in  1  synchronous counter clear.
- stall  out  1  hold PC/IF/ID, bubble into E.
- br_resolve  out  1  branch resolved this cycle.
- br_taken  out  1  resolved and taken; only asserted when br_resolve=1.
- stall_err  out  1  sticky: a stall reached MAX_STALL.
- br_total  out  CNT_W  resolved-branch count.
- br_taken_cnt  out  CNT_W  taken-branch count.

Behaviour:
- Reset, async while reset=0:
  - FSM=IDLE, stall_cnt=0, stall_err=0, both counters 0.
  - Combinational outputs stall, br_resolve and br_taken are forced to 0 while reset is low.
- Hazard (combinational):
  - hz_rs = rs!=0 & ((e_wr_en & e_wr_addr==rs & e_tnew!=0) | (m_wr_en & m_wr_addr==rs & m_tnew!=0)).
  - hz_rt is the same for rt, gated by type BEQ/BNE.
  - hazard = hz_rs | hz_rt. Branch Tuse is 0.
- stall = id_br_valid & hazard, same cycle, combinational.
- br_resolve = id_br_valid & ~hazard, same cycle.
- Condition, 0-cycle latency, signed compare of d1:
  - BEQ: d1==d2. BNE: d1!=d2.
  - BLEZ: d1[31] | d1==0. BGTZ: ~d1[31] & d1!=0.
  - BLTZ: d1[31]. BGEZ: ~d1[31].
- FSM (state and stall_cnt, 2 bits wide enough for MAX_STALL≤3, else ceil log2(MAX_STALL+1)):
  - IDLE:
    - stall=1 → WAIT, stall_cnt=1.
    - Otherwise stay in IDLE, stall_cnt=0.
  - WAIT:
    - stall=1 → stall_cnt increments, saturating at MAX_STALL. When the incremented value equals MAX_STALL, stall_err←1.
    - br_resolve=1 → IDLE, stall_cnt=0.
    - id_br_valid=0 (flush) → IDLE, stall_cnt=0, no resolve, no counter update.
- Performance counters:
  - On br_resolve, br_total+1; if br_taken, br_taken_cnt+1.
  - Both saturate at all-ones.
  - perf_clr has priority over increment and also clears stall_err.
- Simultaneous events:
  - perf_clr with br_resolve in the same cycle → counters end at 0.
  - Producer in both E and M writing rs → stall while either has tnew≠0.
  - A register index of 0 never stalls.
- Reset mid-WAIT → IDLE immediately; outputs drop asynchronously.

Decomposition:
- Shared package holds:
  - br_type_e encodings 0–5.
  - BR_TYPE_W=3, REG_W=5, TNEW_W=2.
  - Helper function uses_rt(type).
- One sub-module, br_cond_eval: combinational; inputs d1, d2, type; output cond.
- Hazard logic, FSM and counters stay in the top module.

Test Plan:
- Hazard-free branch:
  - BEQ, rs=8, rt=9, d1=d2=0x1234, no E/M writes → stall=0, br_resolve=1, br_taken=1 in the same cycle.
  - br_total=1 and br_taken_cnt=1 after the edge.
- Single-cycle stall:
  - BNE, rs=8, e_wr_addr=8, e_tnew=1 for 1 cycle, then e_tnew=0, d1=5, d2=7.
  - Response: cycle0 stall=1, FSM→WAIT; cycle1 resolve with taken=1, FSM→IDLE.
- Signed conditions:
  - BLEZ d1=0x80000000 → taken; BGTZ d1=0 → not taken; BGEZ d1=0 → taken.
  - rt hazard on a BLEZ (rt=9, e_wr_addr=9, e_tnew=2) → no stall.
- Register $0 and stall_err:
  - rs=0 with E writing reg 0, tnew=2 → no stall.
  - rs=8 with m_tnew held at 1 for 4 cycles → stall_err=1 after the 3rd stall edge and stays set until perf_clr.
- Flush and reset:
  - In WAIT, drop id_br_valid → IDLE with counters unchanged.
  - Assert reset low mid-WAIT → stall=0 immediately; counters and stall_err are 0.
- Saturation and clear priority:
  - Force br_total to all-ones via repeated resolves (CNT_W=4 build) → holds at 15.
  - perf_clr together with br_resolve → counters 0 after the edge.
